// File: rtl/direction_toggle_debouncer_if.sv
// ---------------------------------------------------------------------------
// direction_toggle_debouncer_if
//   Groups the button input and the direction/debounce outputs of the
//   direction toggle debouncer.
//   Signals:
//     btn_raw    raw, asynchronous, bouncing button level (1 = pressed)
//     sel        registered direction select (1 = count down, 0 = count up)
//     btn_pulse  one-cycle pulse per accepted press
//     stable     debounced button level
//   Modports:
//     master  drives btn_raw, observes the outputs (button side / bench)
//     slave   the debouncer itself
// ---------------------------------------------------------------------------
interface direction_toggle_debouncer_if;
    logic btn_raw;
    logic sel;
    logic btn_pulse;
    logic stable;

    modport master (
        output btn_raw,
        input  sel,
        input  btn_pulse,
        input  stable
    );

    modport slave (
        input  btn_raw,
        output sel,
        output btn_pulse,
        output stable
    );
endinterface

// File: rtl/direction_toggle_debouncer.sv
// ---------------------------------------------------------------------------
// direction_toggle_debouncer
//   Turns a bouncing push-button into a clean direction select for the 3-bit
//   up/down counter. Every accepted press toggles sel exactly once, no matter
//   how long the button is held. Also exports the debounced level (stable)
//   and a one-cycle press pulse (btn_pulse).
//   Ports:
//     clk    rising-edge clock shared with the counter
//     clear  synchronous active-high reset; overrides everything at its edge
//     bus    slave side of direction_toggle_debouncer_if
//            (btn_raw in; sel, btn_pulse, stable out, all registered)
//   Parameters:
//     DEBOUNCE_CYCLES  samples after the first needed to accept a level (>=1)
//     INIT_DIR         value of sel after reset
// ---------------------------------------------------------------------------
module direction_toggle_debouncer #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic INIT_DIR        = 1'b1
) (
    input  logic                          clk,
    input  logic                          clear,
    direction_toggle_debouncer_if.slave   bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    logic          sync1_q, sync2_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          sel_q, sel_d;
    logic          pulse_q, pulse_d;
    logic          stable_q, stable_d;

    // Saturating increment: the counter must never wrap back to zero.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = IDLE;           // glitch, no toggle
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    sel_d   = ~sel_q;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            default: begin // RELEASE_WAIT
                if (sync2_q) begin
                    state_d = PRESSED;        // release bounce, no new press
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
        endcase
        // Debounced level follows the next state so it is registered with it.
        stable_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= INIT_DIR;
            pulse_q  <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= bus.btn_raw;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            pulse_q  <= pulse_d;
            stable_q <= stable_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.btn_pulse = pulse_q;
    assign bus.stable    = stable_q;

endmodule

// File: tb/tb_direction_toggle_debouncer.sv
module tb_direction_toggle_debouncer;

    logic clk = 1'b0;
    logic clear;
    int   total = 0;
    int   bad   = 0;

    direction_toggle_debouncer_if dut_if ();

    direction_toggle_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .INIT_DIR        (1'b1)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (dut_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        dut_if.btn_raw = 1'b0;
        tick();
        tick();
        clear = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            total++;
            if (dut_if.sel !== 1'b1) begin
                bad++; $display("FAIL reset_sel k=%0d got=%b exp=1", k, dut_if.sel);
            end
            total++;
            if (dut_if.stable !== 1'b0) begin
                bad++; $display("FAIL reset_stable k=%0d got=%b exp=0", k, dut_if.stable);
            end
            total++;
            if (dut_if.btn_pulse !== 1'b0) begin
                bad++; $display("FAIL reset_pulse k=%0d got=%b exp=0", k, dut_if.btn_pulse);
            end
            tick();
        end
        $display("test_reset done: total=%0d bad=%0d", total, bad);
    endtask

    // Press for 10 cycles: toggle at E6 (tick 7), release accepted at E16.
    task automatic test_press_release();
        logic es, ep, est;
        for (int k = 1; k <= 20; k++) begin
            dut_if.btn_raw = (k <= 10);
            tick();
            es  = (k >= 7) ? 1'b0 : 1'b1;
            ep  = (k == 7);
            est = (k >= 7) && (k <= 16);
            total++;
            if (dut_if.sel !== es) begin
                bad++; $display("FAIL press_sel k=%0d got=%b exp=%b", k, dut_if.sel, es);
            end
            total++;
            if (dut_if.btn_pulse !== ep) begin
                bad++; $display("FAIL press_pulse k=%0d got=%b exp=%b", k, dut_if.btn_pulse, ep);
            end
            total++;
            if (dut_if.stable !== est) begin
                bad++; $display("FAIL press_stable k=%0d got=%b exp=%b", k, dut_if.stable, est);
            end
        end
        $display("test_press_release done: total=%0d bad=%0d", total, bad);
    endtask

    // Short bursts 1,1,1,0,0,1,1,1 never reach acceptance; sel stays 0.
    task automatic test_glitch();
        for (int k = 1; k <= 20; k++) begin
            dut_if.btn_raw = (k <= 3) || (k >= 6 && k <= 8);
            tick();
            total++;
            if (dut_if.sel !== 1'b0) begin
                bad++; $display("FAIL glitch_sel k=%0d got=%b exp=0", k, dut_if.sel);
            end
            total++;
            if (dut_if.btn_pulse !== 1'b0) begin
                bad++; $display("FAIL glitch_pulse k=%0d got=%b exp=0", k, dut_if.btn_pulse);
            end
            total++;
            if (dut_if.stable !== 1'b0) begin
                bad++; $display("FAIL glitch_stable k=%0d got=%b exp=0", k, dut_if.stable);
            end
        end
        $display("test_glitch done: total=%0d bad=%0d", total, bad);
    endtask

    // Long hold, then release bounce 0,1,0: one toggle, stable held to E47.
    task automatic test_hold_bounce();
        logic es, ep, est;
        int   pulses = 0;
        for (int k = 1; k <= 60; k++) begin
            dut_if.btn_raw = (k <= 40) || (k == 42);
            tick();
            es  = (k >= 7) ? 1'b1 : 1'b0;
            ep  = (k == 7);
            est = (k >= 7) && (k <= 48);
            if (dut_if.btn_pulse === 1'b1) pulses++;
            total++;
            if (dut_if.sel !== es) begin
                bad++; $display("FAIL hold_sel k=%0d got=%b exp=%b", k, dut_if.sel, es);
            end
            total++;
            if (dut_if.btn_pulse !== ep) begin
                bad++; $display("FAIL hold_pulse k=%0d got=%b exp=%b", k, dut_if.btn_pulse, ep);
            end
            total++;
            if (dut_if.stable !== est) begin
                bad++; $display("FAIL hold_stable k=%0d got=%b exp=%b", k, dut_if.stable, est);
            end
        end
        total++;
        if (pulses != 1) begin
            bad++; $display("FAIL hold_pulse_count got=%0d exp=1", pulses);
        end
        $display("test_hold_bounce done: total=%0d bad=%0d", total, bad);
    endtask

    // Two clean presses 10 low cycles apart: sel 1->0 at tick 7, 0->1 at tick 25.
    task automatic test_back_to_back();
        logic es, ep, est;
        int   pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            dut_if.btn_raw = (k <= 8) || (k >= 19 && k <= 26);
            tick();
            es  = (k >= 7 && k <= 24) ? 1'b0 : 1'b1;
            ep  = (k == 7) || (k == 25);
            est = (k >= 7 && k <= 14) || (k >= 25 && k <= 32);
            if (dut_if.btn_pulse === 1'b1) pulses++;
            total++;
            if (dut_if.sel !== es) begin
                bad++; $display("FAIL b2b_sel k=%0d got=%b exp=%b", k, dut_if.sel, es);
            end
            total++;
            if (dut_if.btn_pulse !== ep) begin
                bad++; $display("FAIL b2b_pulse k=%0d got=%b exp=%b", k, dut_if.btn_pulse, ep);
            end
            total++;
            if (dut_if.stable !== est) begin
                bad++; $display("FAIL b2b_stable k=%0d got=%b exp=%b", k, dut_if.stable, est);
            end
        end
        total++;
        if (pulses != 2) begin
            bad++; $display("FAIL b2b_pulse_count got=%0d exp=2", pulses);
        end
        $display("test_back_to_back done: total=%0d bad=%0d", total, bad);
    endtask

    // Clear while in PRESS_WAIT with the button still held.
    task automatic test_reset_mid();
        logic es, ep, est;
        // Make sel 0 first so the reset value is observable.
        for (int k = 1; k <= 20; k++) begin
            dut_if.btn_raw = (k <= 8);
            tick();
        end
        total++;
        if (dut_if.sel !== 1'b0) begin
            bad++; $display("FAIL mid_pre_sel got=%b exp=0", dut_if.sel);
        end
        dut_if.btn_raw = 1'b1;
        tick();
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++;
        if (dut_if.sel !== 1'b1) begin
            bad++; $display("FAIL mid_clear_sel got=%b exp=1", dut_if.sel);
        end
        total++;
        if (dut_if.stable !== 1'b0) begin
            bad++; $display("FAIL mid_clear_stable got=%b exp=0", dut_if.stable);
        end
        for (int j = 1; j <= 10; j++) begin
            tick();
            es  = (j >= 7) ? 1'b0 : 1'b1;
            ep  = (j == 7);
            est = (j >= 7);
            total++;
            if (dut_if.sel !== es) begin
                bad++; $display("FAIL mid_sel j=%0d got=%b exp=%b", j, dut_if.sel, es);
            end
            total++;
            if (dut_if.btn_pulse !== ep) begin
                bad++; $display("FAIL mid_pulse j=%0d got=%b exp=%b", j, dut_if.btn_pulse, ep);
            end
            total++;
            if (dut_if.stable !== est) begin
                bad++; $display("FAIL mid_stable j=%0d got=%b exp=%b", j, dut_if.stable, est);
            end
        end
        dut_if.btn_raw = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        $display("test_reset_mid done: total=%0d bad=%0d", total, bad);
    endtask

    initial begin
        clear = 1'b1;
        dut_if.btn_raw = 1'b0;
        test_reset();
        test_press_release();
        test_glitch();
        test_hold_bounce();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
